r2sdf_stage: RTL and testbench

R2SDF_STAGE -- requirements
Module: r2sdf_stage

---
 rtl/fft_pkg.sv | 34 +++
 rtl/sdf_delay_line.sv | 37 +++
 rtl/r2sdf_stage.sv | 122 ++++++++++++
 tb/tb_r2sdf_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stages: FSM encoding plus the rounding and
// saturation helpers, which operate on 64-bit signed intermediates.
package fft_pkg;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  // Round half up, then arithmetic shift right by sh (sh >= 1).
  function automatic logic signed [63:0] fn_round_shr(input logic signed [63:0] v, input int sh);
    logic signed [63:0] bias;
    bias = 64'sd1 <<< (sh - 1);
    return (v + bias) >>> sh;
  endfunction

  function automatic logic fn_ovf(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [63:0] fn_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Complex feedback delay of DEPTH samples; shifts only when en is high.
module sdf_delay_line #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  logic signed [DW-1:0] r_line_r [DEPTH];
  logic signed [DW-1:0] r_line_i [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_line_r[i] <= '0;
        r_line_i[i] <= '0;
      end
    end else if (en) begin
      r_line_r[0] <= din_r;
      r_line_i[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_line_r[i] <= r_line_r[i-1];
        r_line_i[i] <= r_line_i[i-1];
      end
    end
  end

  assign dout_r = r_line_r[DEPTH-1];
  assign dout_i = r_line_i[DEPTH-1];

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage: butterfly on FIRST half-frame,
// twiddle multiply of the stored differences on SECOND half-frame.
module r2sdf_stage
  import fft_pkg::*;
#(
  parameter int DW    = 16,
  parameter int TW    = 8,
  parameter int FRAC  = 6,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DW-1:0]         in_r,
  input  logic signed [DW-1:0]         in_i,
  input  logic                         scale,
  output logic [$clog2(DEPTH)-1:0]     tw_addr,
  input  logic signed [TW-1:0]         tw_r,
  input  logic signed [TW-1:0]         tw_i,
  output logic                         out_valid,
  output logic signed [DW-1:0]         out_r,
  output logic signed [DW-1:0]         out_i,
  output logic                         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = DW + TW + 1;

  logic [1:0]           r_state;
  logic [AW-1:0]        r_cnt;
  logic                 r_out_valid;
  logic signed [DW-1:0] r_out_r, r_out_i;
  logic                 r_ovf;

  logic signed [DW-1:0] w_b_r, w_b_i, w_dl_din_r, w_dl_din_i;
  logic signed [DW:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic signed [PW-1:0] w_mul_r, w_mul_i;
  logic signed [63:0]   w_sr, w_si, w_dr, w_di, w_pr, w_pi;
  logic                 w_ovf_now;

  sdf_delay_line #(.DW(DW), .DEPTH(DEPTH)) u_dl (
    .clk    (clk),
    .rst    (rst),
    .en     (in_valid),
    .din_r  (w_dl_din_r),
    .din_i  (w_dl_din_i),
    .dout_r (w_b_r),
    .dout_i (w_b_i)
  );

  // Butterfly at DW+1 bits so the carry is kept before optional halving.
  assign w_sum_r = (DW+1)'(in_r) + (DW+1)'(w_b_r);
  assign w_sum_i = (DW+1)'(in_i) + (DW+1)'(w_b_i);
  assign w_dif_r = (DW+1)'(w_b_r) - (DW+1)'(in_r);
  assign w_dif_i = (DW+1)'(w_b_i) - (DW+1)'(in_i);

  assign w_mul_r = PW'(w_b_r) * PW'(tw_r) - PW'(w_b_i) * PW'(tw_i);
  assign w_mul_i = PW'(w_b_r) * PW'(tw_i) + PW'(w_b_i) * PW'(tw_r);

  always_comb begin
    w_sr = scale ? fn_round_shr(64'(w_sum_r), 1) : 64'(w_sum_r);
    w_si = scale ? fn_round_shr(64'(w_sum_i), 1) : 64'(w_sum_i);
    w_dr = scale ? fn_round_shr(64'(w_dif_r), 1) : 64'(w_dif_r);
    w_di = scale ? fn_round_shr(64'(w_dif_i), 1) : 64'(w_dif_i);
    w_pr = fn_round_shr(64'(w_mul_r), FRAC);
    w_pi = fn_round_shr(64'(w_mul_i), FRAC);

    w_ovf_now = 1'b0;
    if (in_valid && r_state == ST_FIRST)
      w_ovf_now = fn_ovf(w_sr, DW) | fn_ovf(w_si, DW) | fn_ovf(w_dr, DW) | fn_ovf(w_di, DW);
    else if (in_valid && r_state == ST_SECOND)
      w_ovf_now = fn_ovf(w_pr, DW) | fn_ovf(w_pi, DW);

    w_dl_din_r = in_r;
    w_dl_din_i = in_i;
    if (r_state == ST_FIRST) begin
      w_dl_din_r = DW'(fn_sat(w_dr, DW));
      w_dl_din_i = DW'(fn_sat(w_di, DW));
    end
  end

  assign tw_addr = (r_state == ST_SECOND) ? r_cnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= in_valid && (r_state == ST_FIRST || r_state == ST_SECOND);
      r_ovf       <= r_ovf | w_ovf_now;
      if (in_valid) begin
        r_cnt <= r_cnt + AW'(1);
        if (r_state == ST_FIRST) begin
          r_out_r <= DW'(fn_sat(w_sr, DW));
          r_out_i <= DW'(fn_sat(w_si, DW));
        end else if (r_state == ST_SECOND) begin
          r_out_r <= DW'(fn_sat(w_pr, DW));
          r_out_i <= DW'(fn_sat(w_pi, DW));
        end
        // Counter wraps on the same sample that ends each half-frame.
        if (r_cnt == AW'(DEPTH - 1)) begin
          case (r_state)
            ST_FILL:   r_state <= ST_FIRST;
            ST_FIRST:  r_state <= ST_SECOND;
            ST_SECOND: r_state <= ST_FIRST;
            default:   r_state <= ST_FILL;
          endcase
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed bench for r2sdf_stage with DEPTH=2: expected outputs are queued at
// drive time and popped when out_valid is seen one cycle later.
module tb_r2sdf_stage;

  localparam int DW = 16, TW = 8, FRAC = 6, DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_r = '0, in_i = '0;
  logic                 scale = 1'b0;
  logic [0:0]           tw_addr;
  logic signed [TW-1:0] tw_r = 8'sd64, tw_i = 8'sd0;
  logic                 out_valid;
  logic signed [DW-1:0] out_r, out_i;
  logic                 ovf;

  typedef struct { int r; int i; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   last_r = 0, last_i = 0;

  r2sdf_stage #(.DW(DW), .TW(TW), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .scale(scale), .tw_addr(tw_addr), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One input cycle; eaddr < 0 skips the twiddle-address check.
  task automatic send(input logic v, input int r, input int i,
                      input logic ev, input int er, input int ei, input int eaddr);
    exp_t e;
    in_valid = v;
    in_r = DW'(r);
    in_i = DW'(i);
    if (eaddr >= 0) chk("tw_addr", 32'(tw_addr), eaddr);
    if (ev) exp_q.push_back('{er, ei});
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (out_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed empty queue expected entry");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_r", out_r, e.r);
        chk("out_i", out_i, e.i);
        last_r = e.r;
        last_i = e.i;
      end
    end else begin
      chk("hold_r", out_r, last_r);
      chk("hold_i", out_i, last_i);
    end
    $display("in v=%0b (%0d,%0d) -> out v=%0b (%0d,%0d) ovf=%0b", v, r, i, out_valid, out_r, out_i, ovf);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_r = 0;
    last_i = 0;
  endtask

  initial begin
    // Reset state, observed while rst is high and after idle cycles.
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_i", out_i, 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_tw_addr", 32'(tw_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_out_r", out_r, 0);
    end

    // Real butterfly and unity twiddle.
    send(1, 64, 0, 0, 0, 0, 0);
    send(1, 128, 0, 0, 0, 0, 0);
    send(1, 192, 0, 1, 256, 0, 0);
    send(1, 256, 0, 1, 384, 0, 0);
    send(1, 0, 0, 1, -128, 0, 0);
    send(1, 0, 0, 1, -128, 0, 1);

    // Same stream with gaps: values unchanged, out_valid only after valid cycles.
    do_reset();
    send(1, 64, 0, 0, 0, 0, -1);  send(0, 999, 0, 0, 0, 0, -1);
    send(1, 128, 0, 0, 0, 0, -1); send(0, 999, 0, 0, 0, 0, -1);
    send(1, 192, 0, 1, 256, 0, 0); send(0, 999, 0, 0, 0, 0, 0);
    send(1, 256, 0, 1, 384, 0, 0); send(0, 999, 0, 0, 0, 0, 0);
    send(1, 0, 0, 1, -128, 0, 0);  send(0, 999, 0, 0, 0, 0, 1);
    send(1, 0, 0, 1, -128, 0, 1);  send(0, 999, 0, 0, 0, 0, -1);

    // Difference 128+0j times -j*64/64 gives 0-128j.
    do_reset();
    tw_r = 8'sd0; tw_i = -8'sd64;
    send(1, 192, 0, 0, 0, 0, 0);
    send(1, 192, 0, 0, 0, 0, 0);
    send(1, 64, 0, 1, 256, 0, 0);
    send(1, 64, 0, 1, 256, 0, 0);
    send(1, 0, 0, 1, 0, -128, 0);
    send(1, 0, 0, 1, 0, -128, 1);

    // Complex data, twiddle +j*64/64 rotates (r,i) to (-i,r).
    do_reset();
    tw_r = 8'sd0; tw_i = 8'sd64;
    send(1, 10, 20, 0, 0, 0, -1);
    send(1, 30, -40, 0, 0, 0, -1);
    send(1, 5, 6, 1, 15, 26, 0);
    send(1, 7, 8, 1, 37, -32, 0);
    send(1, 0, 0, 1, -14, 5, 0);
    send(1, 0, 0, 1, 48, 23, 1);
    chk("cplx_ovf", 32'(ovf), 0);

    // Scaled butterfly rounds half up: 5->3, -5->-2, 1->1, -1->0.
    do_reset();
    scale = 1'b1; tw_r = 8'sd64; tw_i = 8'sd0;
    send(1, 3, -3, 0, 0, 0, -1);
    send(1, 1, 0, 0, 0, 0, -1);
    send(1, 2, -2, 1, 3, -2, -1);
    send(1, 0, 0, 1, 1, 0, -1);
    send(1, 0, 0, 1, 1, 0, -1);
    send(1, 0, 0, 1, 1, 0, -1);

    // Saturation without scaling sets sticky ovf.
    do_reset();
    scale = 1'b0;
    send(1, 32767, 0, 0, 0, 0, -1);
    send(1, 32767, 0, 0, 0, 0, -1);
    send(1, 32767, 0, 1, 32767, 0, -1);
    chk("sat_ovf", 32'(ovf), 1);
    send(1, 32767, 0, 1, 32767, 0, -1);
    send(1, 0, 0, 1, 0, 0, -1);
    chk("sat_ovf_sticky", 32'(ovf), 1);

    // Same stimulus scaled: no saturation.
    do_reset();
    chk("ovf_cleared", 32'(ovf), 0);
    scale = 1'b1;
    send(1, 32767, 0, 0, 0, 0, -1);
    send(1, 32767, 0, 0, 0, 0, -1);
    send(1, 32767, 0, 1, 32767, 0, -1);
    send(1, 32767, 0, 1, 32767, 0, -1);
    chk("scaled_ovf", 32'(ovf), 0);

    // Reset during FIRST clears outputs at once; restart needs DEPTH+1 samples.
    do_reset();
    scale = 1'b0;
    send(1, 64, 0, 0, 0, 0, -1);
    send(1, 128, 0, 0, 0, 0, -1);
    send(1, 192, 0, 1, 256, 0, -1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_out_r", out_r, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    last_r = 0; last_i = 0;
    send(0, 5, 0, 0, 0, 0, 0);
    send(1, 10, 0, 0, 0, 0, 0);
    send(1, 20, 0, 0, 0, 0, 0);
    send(1, 30, 0, 1, 40, 0, 0);
    send(1, 40, 0, 1, 60, 0, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
